// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word and expands
// the LI / LJ pseudo formats into two-word sequences behind a registered valid/ready slot.
module instr_encoder #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_LI = 3'd6, T_LJ = 3'd7;

  logic [0:0]  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;
  logic [4:0]  sec_rd_q, sec_rd_d;
  logic [4:0]  sec_rs1_q, sec_rs1_d;
  logic [11:0] sec_lo_q, sec_lo_d;
  logic        sec_lj_q, sec_lj_d;

  logic        slot_free, accept;
  logic [31:0] imm_rnd;
  logic signed [31:0] imm_s;
  logic [31:0] enc_instr, sec_instr;
  logic        enc_err_raw, enc_last;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = !rst && (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  // Rounding by 0x800 compensates for the sign extension of the 12-bit low part.
  assign imm_rnd = in_imm + 32'h0000_0800;
  assign imm_s   = $signed(in_imm);

  always_comb begin
    enc_instr   = 32'h0;
    enc_err_raw = 1'b0;
    enc_last    = 1'b1;
    case (in_type)
      T_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      T_I: begin
        enc_instr   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err_raw = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      T_S: begin
        enc_instr   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err_raw = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      T_B: begin
        enc_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
        enc_err_raw = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
      end
      T_U: begin
        enc_instr   = {in_imm[31:12], in_rd, in_opcode};
        enc_err_raw = |in_imm[11:0];
      end
      T_J: begin
        enc_instr   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err_raw = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
      end
      T_LI: begin
        enc_instr = {imm_rnd[31:12], in_rd, 7'b0110111};
        enc_last  = 1'b0;
      end
      default: begin
        enc_instr = {imm_rnd[31:12], in_rs1, 7'b0010111};
        enc_last  = 1'b0;
      end
    endcase
  end

  assign sec_instr = sec_lj_q ? {sec_lo_q, sec_rs1_q, 3'b000, sec_rd_q, 7'b1100111}
                              : {sec_lo_q, sec_rd_q,  3'b000, sec_rd_q, 7'b0010011};

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    sec_rd_d    = sec_rd_q;
    sec_rs1_d   = sec_rs1_q;
    sec_lo_d    = sec_lo_q;
    sec_lj_d    = sec_lj_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (state_q == SECOND) begin
      if (slot_free) begin
        out_valid_d = 1'b1;
        out_instr_d = sec_instr;
        out_err_d   = 1'b0;
        out_last_d  = 1'b1;
        state_d     = IDLE;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_instr;
      out_err_d   = CHECK_EN && enc_err_raw;
      out_last_d  = enc_last;
      if (!enc_last) begin
        state_d   = SECOND;
        sec_rd_d  = in_rd;
        sec_rs1_d = in_rs1;
        sec_lo_d  = in_imm[11:0];
        sec_lj_d  = (in_type == T_LJ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      sec_rd_q    <= 5'd0;
      sec_rs1_q   <= 5'd0;
      sec_lo_q    <= 12'h0;
      sec_lj_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      sec_rd_q    <= sec_rd_d;
      sec_rs1_q   <= sec_rs1_d;
      sec_lo_q    <= sec_lo_d;
      sec_lj_q    <= sec_lj_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, error flags, pseudo
// expansion, backpressure and reset; a CHECK_EN=0 copy runs in lockstep.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready0;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_valid0;
  logic        out_ready;
  logic [31:0] out_instr, out_instr0;
  logic        out_err, out_err0;
  logic        out_last, out_last0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encoder #(.CHECK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
  );

  instr_encoder #(.CHECK_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(out_valid0), .out_ready(out_ready),
    .out_instr(out_instr0), .out_err(out_err0), .out_last(out_last0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    in_type = t; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    #1;
  endtask

  // Present one request, expect it to be accepted at the next edge, then drop in_valid.
  task automatic send(input string tag, input logic [2:0] t, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    set_req(t, op, f3, f7, rd, rs1, rs2, imm);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr,
                             input logic err, input logic last);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_err"},   {31'b0, out_err}, {31'b0, err});
    chk({tag, "_last"},  {31'b0, out_last}, {31'b0, last});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_type = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    tick(); tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_last",  {31'b0, out_last}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // addi x5, x6, -1
    send("i_neg1", 3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    expect_word("i_neg1", 32'hFFF3_0293, 1'b0, 1'b1);
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    send("b_8", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_word("b_8", 32'h0020_8463, 1'b0, 1'b1);
    send("b_9", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd9);
    expect_word("b_9", 32'h0020_8463, 1'b1, 1'b1);
    // sw x2, -4(x1)
    send("s_m4", 3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    expect_word("s_m4", 32'hFE20_AE23, 1'b0, 1'b1);
    send("u_ok", 3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
    expect_word("u_ok", 32'h1234_50B7, 1'b0, 1'b1);
    send("u_bad", 3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5001);
    expect_word("u_bad", 32'h1234_50B7, 1'b1, 1'b1);
    send("j_2048", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    expect_word("j_2048", 32'h0010_00EF, 1'b0, 1'b1);
    send("j_ovf", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
    expect_word("j_ovf", 32'h8000_00EF, 1'b1, 1'b1);
    send("i_2048", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    expect_word("i_2048", 32'h8000_0093, 1'b1, 1'b1);
    chk("i_2048_imm_field", {20'b0, out_instr[31:20]}, 32'h800);
    chk("i_2048_nochk_err", {31'b0, out_err0}, 32'd0);
    chk("i_2048_nochk_instr", out_instr0, 32'h8000_0093);
    tick();

    // LI x10, 0x12345FFF; fields scrambled after acceptance must not matter
    send("li", 3'd6, 7'h00, 3'd0, 7'd0, 5'd10, 5'd3, 5'd0, 32'h1234_5FFF);
    in_rd = 5'd31; in_imm = 32'h0; in_type = 3'd0; #1;
    expect_word("li_w1", 32'h1234_6537, 1'b0, 1'b0);
    chk("li_second_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    expect_word("li_w2", 32'hFFF5_0513, 1'b0, 1'b1);
    chk("li_done_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // LJ far jump: auipc x5,1 ; jalr x1,0(x5)
    send("lj", 3'd7, 7'h00, 3'd0, 7'd0, 5'd1, 5'd5, 5'd0, 32'h0000_1000);
    expect_word("lj_w1", 32'h0000_1297, 1'b0, 1'b0);
    tick();
    expect_word("lj_w2", 32'h0002_80E7, 1'b0, 1'b1);
    tick();

    // Backpressure: sub x1, x2, x3 held while out_ready=0
    out_ready = 1'b0;
    send("r_bp", 3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      expect_word("r_bp_hold", 32'h4031_00B3, 1'b0, 1'b1);
      chk("r_bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("r_bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    expect_word("r_bp_next", 32'hFFF3_0293, 1'b0, 1'b1);
    tick();

    // Reset while the LI second word is pending
    send("li_rst", 3'd6, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    expect_word("li_rst_w1", 32'h1234_6537, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("mid_rst_no_second", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_in_ready2", {31'b0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
